button_input: RTL

BUTTON_INPUT -- requirements
Module: button_input

---
 rtl/button_input_pkg.sv | 51 +++++
 rtl/button_input_debounce.sv | 56 +++++
 rtl/button_input.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/button_input_pkg.sv
// -----------------------------------------------------------------------------
// button_input_pkg
// Shared constants for the button front end: colour FSM state encodings,
// the default debounce length and small helpers used by the colour FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package button_input_pkg;

    localparam int CNT_W = 25;

    // Default number of stable synced cycles before a change is accepted.
    localparam logic [CNT_W-1:0] DEBOUNCE_CYCLES_DEF = 25'd500_000;

    // Three bits wide so that illegal encodings exist and can be recovered.
    typedef enum logic [2:0] {
        BI_IDLE       = 3'd0,
        BI_PRESS_DB   = 3'd1,
        BI_HELD       = 3'd2,
        BI_RELEASE_DB = 3'd3
    } bi_state_t;

    // True when exactly one bit of the 4-bit button mask is set.
    function automatic logic is_onehot(input logic [3:0] m);
        return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
    endfunction

    // One-hot colour mask to 2-bit colour code.
    function automatic logic [1:0] encode_onehot(input logic [3:0] m);
        logic [1:0] code_s;
        case (m)
            4'b0001: code_s = 2'd0;
            4'b0010: code_s = 2'd1;
            4'b0100: code_s = 2'd2;
            4'b1000: code_s = 2'd3;
            default: code_s = 2'd0;
        endcase
        return code_s;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r_s;
        if (c == {CNT_W{1'b1}}) begin
            r_s = c;
        end else begin
            r_s = c + 25'd1;
        end
        return r_s;
    endfunction

endpackage

// File: rtl/button_input_debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Level filter: Q follows D only after D has disagreed with Q for CYCLES
// consecutive cycles; any cycle of agreement restarts the count.
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset (Q and counter cleared)
//   D      already-synchronized input level
//   Q      filtered level, driven from a flop
// -----------------------------------------------------------------------------
module debounce
    import button_input_pkg::*;
#(
    parameter logic [CNT_W-1:0] CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             q_r;
    logic             q_nxt_s;

    // Next-state: count disagreement cycles, flip once CYCLES have been seen.
    always_comb begin
        cnt_nxt_s = cnt_r;
        q_nxt_s   = q_r;
        if (D != q_r) begin
            if (cnt_r >= CYCLES) begin
                q_nxt_s   = D;
                cnt_nxt_s = 25'd0;
            end else begin
                cnt_nxt_s = sat_inc(cnt_r);
            end
        end else begin
            cnt_nxt_s = 25'd0;
        end
    end

    // Filter state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= 25'd0;
            q_r   <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            q_r   <= q_nxt_s;
        end
    end

    assign Q = q_r;

endmodule

// File: rtl/button_input.sv
// -----------------------------------------------------------------------------
// button_input
// Synchronizes and debounces four colour buttons and a start button.
// A colour is reported only while exactly one colour button is held stably;
// the start button is filtered independently into a clean level.
// Ports:
//   CLK         clock, rising edge
//   RST_N       asynchronous active-low reset
//   BTN[3:0]    raw colour buttons, active-high, BTN[k] = colour k
//   START_BTN   raw start button, active-high
//   IN[1:0]     colour code of the held button (holds while IN_VALID low)
//   IN_VALID    high while one debounced colour button is held
//   START_GAME  debounced START_BTN level
// -----------------------------------------------------------------------------
module button_input
    import button_input_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] BTN,
    input  logic       START_BTN,
    output logic [1:0] IN,
    output logic       IN_VALID,
    output logic       START_GAME
);

    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - 25'd1;

    logic [3:0]       btn_s1_r;
    logic [3:0]       btn_s2_r;
    logic             start_s1_r;
    logic             start_s2_r;

    bi_state_t        state_r;
    bi_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       mask_r;
    logic [3:0]       mask_nxt_s;
    logic [1:0]       in_r;
    logic [1:0]       in_nxt_s;
    logic             in_valid_r;
    logic             in_valid_nxt_s;

    // Two-flop synchronizers for all raw button inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_s1_r   <= 4'd0;
            btn_s2_r   <= 4'd0;
            start_s1_r <= 1'b0;
            start_s2_r <= 1'b0;
        end else begin
            btn_s1_r   <= BTN;
            btn_s2_r   <= btn_s1_r;
            start_s1_r <= START_BTN;
            start_s2_r <= start_s1_r;
        end
    end

    // Colour FSM next-state and next-output logic.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        mask_nxt_s     = mask_r;
        in_nxt_s       = in_r;
        in_valid_nxt_s = in_valid_r;
        case (state_r)
            BI_IDLE: begin
                in_valid_nxt_s = 1'b0;
                // Multi-button or empty input is never captured.
                if (is_onehot(btn_s2_r)) begin
                    mask_nxt_s  = btn_s2_r;
                    cnt_nxt_s   = 25'd0;
                    state_nxt_s = BI_PRESS_DB;
                end else begin
                    state_nxt_s = BI_IDLE;
                end
            end
            BI_PRESS_DB: begin
                in_valid_nxt_s = 1'b0;
                if (btn_s2_r != mask_r) begin
                    state_nxt_s = BI_IDLE;
                end else if (cnt_r == DB_LAST) begin
                    state_nxt_s    = BI_HELD;
                    in_nxt_s       = encode_onehot(mask_r);
                    in_valid_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            BI_HELD: begin
                in_valid_nxt_s = 1'b1;
                if (btn_s2_r != mask_r) begin
                    cnt_nxt_s   = 25'd0;
                    state_nxt_s = BI_RELEASE_DB;
                end else begin
                    state_nxt_s = BI_HELD;
                end
            end
            BI_RELEASE_DB: begin
                in_valid_nxt_s = 1'b1;
                if (btn_s2_r == mask_r) begin
                    // Bounce back to the held button: stay held.
                    state_nxt_s = BI_HELD;
                end else if (btn_s2_r != 4'd0) begin
                    // A different button is still down: restart the release.
                    cnt_nxt_s = 25'd0;
                end else if (cnt_r == DB_LAST) begin
                    state_nxt_s    = BI_IDLE;
                    in_valid_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            default: begin
                state_nxt_s    = BI_IDLE;
                cnt_nxt_s      = 25'd0;
                in_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Colour FSM state and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= BI_IDLE;
            cnt_r      <= 25'd0;
            mask_r     <= 4'd0;
            in_r       <= 2'd0;
            in_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            mask_r     <= mask_nxt_s;
            in_r       <= in_nxt_s;
            in_valid_r <= in_valid_nxt_s;
        end
    end

    debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_start_db (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (start_s2_r),
        .Q     (START_GAME)
    );

    assign IN       = in_r;
    assign IN_VALID = in_valid_r;

endmodule
